// File: rtl/move_scheduler_pkg.sv
// move_sched_pkg: shared types and defaults for the move scheduler slice.
//   sched_state_t : scheduler FSM state encoding
//   move_t        : one queued move at the default data width
//                   (duration, increment, incinc, dir; 3*DATA_W+1 bits)
//   DEPTH_BITS_DEF / DATA_W_DEF : default queue depth exponent and data width
package move_sched_pkg;

  localparam int unsigned DEPTH_BITS_DEF = 2;
  localparam int unsigned DATA_W_DEF     = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } sched_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] duration;
    logic [DATA_W_DEF-1:0] increment;
    logic [DATA_W_DEF-1:0] incinc;
    logic                  dir;
  } move_t;

endpackage

// File: rtl/move_scheduler_if.sv
// move_scheduler_if: move-commit channel from the SPI command decoder.
//   wr_valid     decoder -> scheduler  one-cycle commit strobe
//   wr_ready     scheduler -> decoder  queue can take a move (BUFFER_DTR)
//   wr_duration  decoder -> scheduler  duration in DDA ticks
//   wr_increment decoder -> scheduler  signed step-rate increment
//   wr_incinc    decoder -> scheduler  signed increment-increment
//   wr_dir       decoder -> scheduler  direction bit
// master = decoder side, slave = scheduler side.
interface move_scheduler_if
  import move_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_duration;
  logic [DATA_W-1:0] wr_increment;
  logic [DATA_W-1:0] wr_incinc;
  logic              wr_dir;

  modport master (
    output wr_valid, wr_duration, wr_increment, wr_incinc, wr_dir,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_duration, wr_increment, wr_incinc, wr_dir,
    output wr_ready
  );

endinterface

// File: rtl/move_scheduler_fifo.sv
// move_fifo: circular move queue for the scheduler.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i         store wdata_i at the write pointer (ignored when full)
//   pop_i          advance the read pointer (ignored when empty)
//   flush_i        discard all entries; wins over push/pop
//   wdata_i        entry to store
//   rdata_o        head entry (combinational read of the read pointer)
//   occupancy_o    registered entry count, 0 .. 2^DEPTH_BITS
//   full_o/empty_o status from the registered count
module move_fifo
  import move_sched_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int unsigned WIDTH      = 3 * DATA_W_DEF + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [DEPTH_BITS:0]   occupancy_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned         DEPTH    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wptr_q, wptr_d;
  logic [DEPTH_BITS-1:0] rptr_q, rptr_d;
  logic [DEPTH_BITS:0]   occ_q, occ_d;
  logic                  do_push, do_pop;

  assign full_o      = (occ_q == FULL_CNT);
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign rdata_o     = mem_q[rptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Storage needs no reset: only entries covered by occ_q are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: queues committed moves and feeds them one at a time to
// dda_timer, with a fixed two-cycle gap (LOAD then RUN) between moves.
//   CLK, reset       clock, asynchronous active-high reset
//   wr (slave)       move commit channel; wr_ready doubles as BUFFER_DTR
//   dda_start        one-cycle pulse in the first RUN cycle
//   dda_duration/dda_increment/dda_incinc/dda_dir  active move, stable in RUN
//   dda_done         end-of-move pulse from the timer (ignored outside RUN)
//   move_done        one-cycle pulse when the last queued move finishes
//   occupancy        queued moves, excluding the active one
//   overflow         sticky: commit seen while wr_ready low
//   clear_flags      clears overflow (wins over a same-cycle set)
//   halt, dda_abort  only with MOVE_SCHED_HALT_EN defined: halt flushes the
//                    queue and idles; dda_abort pulses if a move was running
module move_scheduler
  import move_sched_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic                CLK,
  input  logic                reset,
  move_scheduler_if.slave     wr,
  output logic                dda_start,
  output logic [DATA_W-1:0]   dda_duration,
  output logic [DATA_W-1:0]   dda_increment,
  output logic [DATA_W-1:0]   dda_incinc,
  output logic                dda_dir,
  input  logic                dda_done,
  output logic                move_done,
  output logic [DEPTH_BITS:0] occupancy,
  output logic                overflow,
  input  logic                clear_flags
`ifdef MOVE_SCHED_HALT_EN
  ,
  input  logic                halt,
  output logic                dda_abort
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] duration;
    logic [DATA_W-1:0] increment;
    logic [DATA_W-1:0] incinc;
    logic              dir;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  sched_state_t       state_q;
  logic               dda_start_q, move_done_q, overflow_q;
  logic [DATA_W-1:0]  dur_q, inc_q, incinc_q;
  logic               dir_q;
  entry_t             wr_entry, head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic               halt_w, fifo_full, fifo_empty, push_w, pop_w;

`ifdef MOVE_SCHED_HALT_EN
  logic dda_abort_q;
  assign halt_w    = halt;
  assign dda_abort = dda_abort_q;
`else
  assign halt_w = 1'b0;
`endif

  // Ready comes from the registered count, so a full queue rejects a push
  // even in the cycle its head is popped.
  assign wr.wr_ready = ~fifo_full & ~halt_w;
  assign push_w      = wr.wr_valid & wr.wr_ready;
  assign pop_w       = (state_q == ST_LOAD) & ~halt_w;

  assign wr_entry = '{duration:  wr.wr_duration,
                      increment: wr.wr_increment,
                      incinc:    wr.wr_incinc,
                      dir:       wr.wr_dir};
  assign head_entry = entry_t'(head_bits);

  move_fifo #(
    .DEPTH_BITS (DEPTH_BITS),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (reset),
    .push_i      (push_w),
    .pop_i       (pop_w),
    .flush_i     (halt_w),
    .wdata_i     (wr_entry),
    .rdata_o     (head_bits),
    .occupancy_o (occupancy),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dda_start_q <= 1'b0;
      move_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      dur_q       <= '0;
      inc_q       <= '0;
      incinc_q    <= '0;
      dir_q       <= 1'b0;
`ifdef MOVE_SCHED_HALT_EN
      dda_abort_q <= 1'b0;
`endif
    end else begin
      dda_start_q <= 1'b0;
      move_done_q <= 1'b0;
`ifdef MOVE_SCHED_HALT_EN
      dda_abort_q <= 1'b0;
`endif
      if (clear_flags)
        overflow_q <= 1'b0;
      else if (wr.wr_valid && !wr.wr_ready)
        overflow_q <= 1'b1;

      if (halt_w) begin
        state_q <= ST_IDLE;
`ifdef MOVE_SCHED_HALT_EN
        dda_abort_q <= (state_q == ST_RUN);
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty) state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            dur_q       <= head_entry.duration;
            inc_q       <= head_entry.increment;
            incinc_q    <= head_entry.incinc;
            dir_q       <= head_entry.dir;
            dda_start_q <= 1'b1;
            state_q     <= ST_RUN;
          end
          ST_RUN: begin
            if (dda_done) begin
              if (!fifo_empty) begin
                state_q <= ST_LOAD;
              end else begin
                state_q     <= ST_IDLE;
                move_done_q <= 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dda_start     = dda_start_q;
  assign move_done     = move_done_q;
  assign overflow      = overflow_q;
  assign dda_duration  = dur_q;
  assign dda_increment = inc_q;
  assign dda_incinc    = incinc_q;
  assign dda_dir       = dir_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed scoreboard bench for move_scheduler.
// Stimulus pushes expected started moves, start cycles and move_done cycles
// into queues; a negedge monitor pops and compares whenever dda_start or
// move_done is seen. Halt scenario is built when MOVE_SCHED_HALT_EN is set.
module tb_move_scheduler;
  import move_sched_pkg::*;

  logic       CLK = 1'b0;
  logic       reset;
  logic       dda_start, dda_dir, dda_done, move_done, overflow, clear_flags;
  logic [63:0] dda_duration, dda_increment, dda_incinc;
  logic [2:0] occupancy;
`ifdef MOVE_SCHED_HALT_EN
  logic       halt, dda_abort;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  move_t exp_q[$];
  int    exp_t[$];
  int    exp_md[$];

  move_scheduler_if #(.DATA_W(64)) wr_if ();

  move_scheduler #(
    .DEPTH_BITS (2),
    .DATA_W     (64)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .wr            (wr_if),
    .dda_start     (dda_start),
    .dda_duration  (dda_duration),
    .dda_increment (dda_increment),
    .dda_incinc    (dda_incinc),
    .dda_dir       (dda_dir),
    .dda_done      (dda_done),
    .move_done     (move_done),
    .occupancy     (occupancy),
    .overflow      (overflow),
    .clear_flags   (clear_flags)
`ifdef MOVE_SCHED_HALT_EN
    ,
    .halt          (halt),
    .dda_abort     (dda_abort)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic move_t mk(input logic [63:0] d, input logic [63:0] i,
                               input logic [63:0] ii, input logic dir);
    move_t m;
    m.duration  = d;
    m.increment = i;
    m.incinc    = ii;
    m.dir       = dir;
    return m;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle commit; 'accepted' means the move is expected to start later.
  task automatic commit(input move_t m, input bit accepted);
    wr_if.wr_valid     = 1'b1;
    wr_if.wr_duration  = m.duration;
    wr_if.wr_increment = m.increment;
    wr_if.wr_incinc    = m.incinc;
    wr_if.wr_dir       = m.dir;
    if (accepted) exp_q.push_back(m);
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  // mode 0: expect move_done next cycle; 1: expect dda_start two cycles on;
  // 2: expect nothing.
  task automatic done_pulse(input int mode);
    dda_done = 1'b1;
    if (mode == 0) exp_md.push_back(cyc + 1);
    if (mode == 1) exp_t.push_back(cyc + 2);
    tick();
    dda_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_wr_ready"}, 64'(wr_if.wr_ready), 64'd1);
    chk({tag, "_dda_start"}, 64'(dda_start), 64'd0);
    chk({tag, "_move_done"}, 64'(move_done), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_dda_duration"}, dda_duration, 64'd0);
    chk({tag, "_dda_increment"}, dda_increment, 64'd0);
    chk({tag, "_dda_dir"}, 64'(dda_dir), 64'd0);
  endtask

  // Monitor: compares every start / move_done against the scoreboard.
  always @(negedge CLK) begin
    move_t e;
    int    t;
    if (!reset) begin
      if (dda_start) begin
        if (exp_q.size() == 0 || exp_t.size() == 0) begin
          chk("start_unexpected", 64'(dda_start), 64'd0);
        end else begin
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          chk("start_cycle", 64'(cyc), 64'(t));
          chk("start_duration", dda_duration, e.duration);
          chk("start_increment", dda_increment, e.increment);
          chk("start_incinc", dda_incinc, e.incinc);
          chk("start_dir", 64'(dda_dir), 64'(e.dir));
        end
      end
      if (move_done) begin
        if (exp_md.size() == 0) begin
          chk("move_done_unexpected", 64'(move_done), 64'd0);
        end else begin
          t = exp_md.pop_front();
          chk("move_done_cycle", 64'(cyc), 64'(t));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    move_t m1, m2, m3, m4, m5, m6, mx, m7, m8, m9;
    m1 = mk(64'd100, 64'd5, 64'd0, 1'b1);
    m2 = mk(64'd200, 64'd7, 64'd1, 1'b0);
    m3 = mk(64'd300, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 1'b1);
    m4 = mk(64'd400, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    m5 = mk(64'd500, 64'd11, 64'd0, 1'b1);
    m6 = mk(64'd600, 64'd13, 64'd3, 1'b0);
    mx = mk(64'd999, 64'd1, 64'd1, 1'b1);
    m7 = mk(64'd700, 64'd17, 64'd4, 1'b1);
    m8 = mk(64'd800, 64'd19, 64'd5, 1'b0);
    m9 = mk(64'd900, 64'd23, 64'd6, 1'b1);

    reset = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_duration = '0;
    wr_if.wr_increment = '0;
    wr_if.wr_incinc = '0;
    wr_if.wr_dir = 1'b0;
    dda_done = 1'b0;
    clear_flags = 1'b0;
`ifdef MOVE_SCHED_HALT_EN
    halt = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b0;
    check_reset_vals("reset");

    // Single move into an idle scheduler: start two edges after acceptance.
    exp_t.push_back(cyc + 3);
    commit(m1, 1'b1);
    chk("s1_occ_after_commit", 64'(occupancy), 64'd1);
    tick();
    chk("s1_occ_in_load", 64'(occupancy), 64'd1);
    tick();
    chk("s1_occ_in_run", 64'(occupancy), 64'd0);
    chk("s1_dda_start", 64'(dda_start), 64'd1);

    // Fill the queue behind the running move, then overflow.
    commit(m2, 1'b1);
    commit(m3, 1'b1);
    commit(m4, 1'b1);
    chk("s2_ready_at_3", 64'(wr_if.wr_ready), 64'd1);
    commit(m5, 1'b1);
    chk("s2_occ_full", 64'(occupancy), 64'd4);
    chk("s2_ready_full", 64'(wr_if.wr_ready), 64'd0);
    commit(mx, 1'b0);
    chk("s2_overflow_set", 64'(overflow), 64'd1);
    chk("s2_occ_after_reject", 64'(occupancy), 64'd4);
    clear_flags = 1'b1;
    commit(mx, 1'b0);
    clear_flags = 1'b0;
    chk("s2_clear_priority", 64'(overflow), 64'd0);

    // Drain in FIFO order with the two-cycle gap.
    done_pulse(1);
    tick();
    chk("s3_occ_3", 64'(occupancy), 64'd3);
    done_pulse(1);
    tick();
    chk("s3_occ_2", 64'(occupancy), 64'd2);

    // Push in the LOAD cycle (same edge as the pop) across pointer wrap.
    done_pulse(1);
    commit(m6, 1'b1);
    chk("s4_occ_push_pop", 64'(occupancy), 64'd2);
    done_pulse(1);
    tick();
    chk("s4_occ_1", 64'(occupancy), 64'd1);
    done_pulse(1);
    tick();
    chk("s4_occ_0", 64'(occupancy), 64'd0);
    done_pulse(0);
    tick();

    // dda_done while idle must do nothing.
    done_pulse(2);
    chk("idle_done_no_move_done", 64'(move_done), 64'd0);
    tick();
    chk("idle_done_no_start", 64'(dda_start), 64'd0);

    // Asynchronous reset in the middle of a run with one move queued.
    exp_t.push_back(cyc + 3);
    commit(m7, 1'b1);
    commit(m8, 1'b1);
    tick();
    tick();
    chk("rst_occ_before", 64'(occupancy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_t.delete();
    exp_md.delete();
    check_reset_vals("midrun_reset");
    tick();
    reset = 1'b0;
    exp_t.push_back(cyc + 3);
    commit(m9, 1'b1);
    chk("post_rst_occ_1", 64'(occupancy), 64'd1);
    tick();
    tick();
    chk("post_rst_occ_0", 64'(occupancy), 64'd0);
    chk("post_rst_duration", dda_duration, 64'd900);
    done_pulse(0);
    tick();

`ifdef MOVE_SCHED_HALT_EN
    // Halt during RUN with three queued; same-cycle commit and done lose.
    exp_t.push_back(cyc + 3);
    commit(m1, 1'b1);
    commit(m2, 1'b0);
    commit(m3, 1'b0);
    commit(m4, 1'b0);
    chk("halt_occ_before", 64'(occupancy), 64'd3);
    halt = 1'b1;
    dda_done = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_duration = mx.duration;
    #1;
    chk("halt_ready_low", 64'(wr_if.wr_ready), 64'd0);
    tick();
    halt = 1'b0;
    dda_done = 1'b0;
    wr_if.wr_valid = 1'b0;
    chk("halt_abort", 64'(dda_abort), 64'd1);
    chk("halt_occ_flushed", 64'(occupancy), 64'd0);
    chk("halt_overflow", 64'(overflow), 64'd1);
    chk("halt_no_move_done", 64'(move_done), 64'd0);
    tick();
    chk("halt_abort_one_cycle", 64'(dda_abort), 64'd0);
    chk("halt_no_restart", 64'(dda_start), 64'd0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("halt_overflow_cleared", 64'(overflow), 64'd0);
`endif

    repeat (3) tick();
    chk("drain_moves", 64'(exp_q.size()), 64'd0);
    chk("drain_start_times", 64'(exp_t.size()), 64'd0);
    chk("drain_move_done", 64'(exp_md.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequences buffered coordinated moves into the DDA step timer. Sits between the SPI command decoder, which commits fully received moves, and `dda_timer`. Owns a circular move queue with read/write pointers and occupancy, loads the head move into the timer, and advances on move completion. Drives the host flow-control signal (buffer data-terminal-ready) and the move-done event.

## Interface
Parameters:
- `DEPTH_BITS`, default 2: queue depth is 2^DEPTH_BITS entries (default 4).
- `DATA_W`, default 64: width of duration, increment and increment-increment.

Ports:
- `CLK`  in  1  sole clock; SPI and DDA domains are both already on `CLK`.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  one-cycle commit of a complete move from the decoder.
- `wr_ready`  out  1  queue not full and not halting; exported as BUFFER_DTR.
- `wr_duration`  in  DATA_W  move duration in DDA ticks.
- `wr_increment`  in  DATA_W  signed step-rate increment.
- `wr_incinc`  in  DATA_W  signed increment-increment.
- `wr_dir`  in  1  direction bit.
- `dda_start`  out  1  one-cycle pulse: timer begins the move on `dda_*`.
- `dda_duration` / `dda_increment` / `dda_incinc`  out  DATA_W  active move parameters.
- `dda_dir`  out  1  active direction.
- `dda_done`  in  1  one-cycle pulse from the timer at end of move.
- `move_done`  out  1  one-cycle pulse when the last queued move finishes and the queue is empty.
- `occupancy`  out  DEPTH_BITS+1  number of queued moves, excluding the active move.
- `overflow`  out  1  sticky; set when a commit arrives while `wr_ready` is low.
- `clear_flags`  in  1  clears `overflow`.
- `halt`  in  1  present only with `MOVE_SCHED_HALT_EN`.
- `dda_abort`  out  1  present only with `MOVE_SCHED_HALT_EN`.

## Operation
- FSM states: IDLE, LOAD, RUN.
  - IDLE: no active move. If `occupancy != 0`, go to LOAD.
  - LOAD: lasts one cycle. Pops the head entry into the `dda_*` output registers, then goes to RUN.
  - RUN: `dda_start` is high in the first RUN cycle only. `dda_*` stay stable for the whole of RUN.
  - On `dda_done` in RUN: go to LOAD if `occupancy != 0`. Otherwise go to IDLE and pulse `move_done`.
- `dda_done` outside RUN is ignored.
- Write rules:
  - A commit with `wr_valid & wr_ready` stores the entry at the write pointer and increments the pointer. Pointers wrap modulo depth.
  - A commit with `wr_valid & !wr_ready` is dropped and sets `overflow`. `clear_flags` has priority over a same-cycle set.
- A push and a pop in the same cycle leave `occupancy` unchanged. When full, that push is still rejected, because `wr_ready` is computed from the pre-pop count.
- `wr_ready = (occupancy != 2^DEPTH_BITS)`, gated by halt when the feature is present.
- Reset values: state IDLE; pointers 0; `occupancy` 0; all `dda_*` 0; `dda_start`, `move_done`, `overflow`, `dda_abort` 0; `wr_ready` 1.
- Reset mid-move discards the queue and the active move immediately.

## Timing
- Commit into an empty IDLE scheduler accepted at edge N:
  - `occupancy` = 1 after N.
  - LOAD during cycle N+1.
  - `dda_start` high and `dda_*` valid during cycle N+2.
  - `occupancy` back to 0 after N+2.
- Back-to-back moves: `dda_done` at cycle M gives LOAD at M+1 and `dda_start` at M+2. There is a fixed two-cycle gap between moves.
- `move_done` is high in the cycle after the final `dda_done`.
- All outputs are registered except `wr_ready`, which is combinational from registered state.

## Configuration
- `MOVE_SCHED_HALT_EN` defined:
  - `halt` and `dda_abort` ports exist.
  - `halt` high from any state: next state IDLE, queue flushed (pointers equal, `occupancy` 0), `move_done` not pulsed.
  - If the state was RUN, `dda_abort` pulses for one cycle.
  - `wr_ready` is low while `halt` is high; commits in that window set `overflow`.
  - `halt` has priority over a same-cycle `dda_done` or commit.
- Undefined: both ports are absent and halt logic is not built.

## Structure
- Package `move_sched_pkg`:
  - FSM state enum.
  - Move-entry struct: duration, increment, incinc, dir; 3·DATA_W+1 bits.
  - Default `DEPTH_BITS`.
- Sub-module `move_fifo`: entry storage array, wrapping pointers, occupancy counter, full/empty. The FSM and the DDA output registers stay in `move_scheduler`.

## Test plan
- Reset, then one commit (duration 100, inc 5, incinc 0, dir 1) → `dda_start` exactly 2 cycles after commit with those values; `occupancy` 1 → 0.
- Commit 4 moves while the first runs (depth 4) → `wr_ready` drops after the 4th queued entry; a 5th commit sets `overflow`, and `clear_flags` clears it.
- Pulse `dda_done` 4 times → 4 `dda_start` pulses in FIFO order, each 2 cycles after `dda_done`; `move_done` once after the last.
- Push and `dda_done` pop in the same cycle at occupancy 2 → occupancy stays 2 and the entry order is preserved across pointer wrap.
- `MOVE_SCHED_HALT_EN`: `halt` during RUN with 3 queued → `dda_abort` pulse, occupancy 0, IDLE, no `move_done`, commit during halt rejected.
- Assert `reset` mid-RUN → all outputs return to reset values asynchronously; the next commit behaves as in the first scenario.
